pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter for the pipelined core and sequences instruction fetch: one request to instruction memory at a time, one-entry IF output buffer toward decode.
- Applies branch/jump redirects as target = br_pc + (br_immd << 1) and flushes wrong-path fetches.
- Sits between the imem port and the IF/ID boundary; the hazard unit drives id_ready; EX drives br_taken.

Parameters:
- XLEN, 64, address/PC width.
- RESET_VECTOR, 64'h0000_0000_0000_1000, PC value after reset.
- TRAP_VECTOR, 64'h0000_0000_0000_0100, misaligned-target vector (optional feature only).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request, valid in REQ state only.
- imem_addr  out  XLEN  fetch address (= pc_q in REQ, else 0).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  IF buffer holds an instruction.
- if_pc  out  XLEN  PC of buffered instruction.
- if_instr  out  32  buffered instruction.
- id_ready  in  1  decode consumes the buffer this cycle (0 = stall).
- br_taken  in  1  single-cycle redirect pulse.
- br_pc  in  XLEN  PC of the redirecting instruction.
- br_immd  in  XLEN  sign-extended immediate (halfword units).
- flush  out  1  wrong-path kill to IF/ID, registered.

Behaviour:
- Reset (rst_n=0, immediate): state=IDLE, pc_q=RESET_VECTOR, discard=0. All outputs 0: imem_req, imem_addr, if_valid, if_pc, if_instr, flush.
- Target arithmetic: br_pc + (br_immd << 1), truncated mod 2^XLEN. Sequential next PC: pc_q + 4, mod 2^XLEN.
- flush is 1 for exactly the cycle after any cycle in which br_taken=1; otherwise 0.
- IDLE:
  - Advances to REQ on the first clock after reset release.
  - imem_rvalid is ignored.
- REQ:
  - imem_req=1, imem_addr=pc_q.
  - gnt=1, br_taken=0: pending_pc<=pc_q, pc_q<=pc_q+4, go to WAIT.
  - gnt=1, br_taken=1: pc_q<=target, discard<=1, go to WAIT.
  - gnt=0, br_taken=1: pc_q<=target, stay in REQ.
  - gnt=0, br_taken=0: hold.
- WAIT:
  - imem_req=0.
  - rvalid=1 with discard=1 or br_taken=1: response dropped, discard<=0, go to REQ.
  - rvalid=1, otherwise: if_pc<=pending_pc, if_instr<=rdata, if_valid<=1, go to HOLD.
  - br_taken=1 with rvalid=0: pc_q<=target, discard<=1, stay in WAIT.
- HOLD:
  - if_valid=1; buffer and pc_q are stable while id_ready=0.
  - id_ready=1: if_valid<=0, go to REQ.
  - br_taken=1 (takes priority over id_ready): if_valid<=0, pc_q<=target, go to REQ.
- Fetch latency: at most one outstanding request. Minimum 3 cycles per instruction with gnt in the REQ cycle, rvalid the next cycle and id_ready=1.
- rvalid outside WAIT is ignored.
- A redirect never lets a wrong-path instruction reach if_valid=1.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_trap (1 bit, reset 0).
  - When a computed target has target[1:0]≠0, pc_q<=TRAP_VECTOR instead of the target.
  - misalign_trap=1 for exactly the cycle after that br_taken.
- Undefined:
  - No port.
  - The target is loaded unmodified, and misaligned addresses reach imem_addr.

Test Plan:
- Reset release, gnt=1 in REQ, rvalid next cycle, id_ready=1 → imem_addr 0x1000 then 0x1004; if_pc=0x1000, if_instr=rdata; steady 3-cycle cadence.
- id_ready=0 for 3 cycles with buffer full → if_valid, if_pc, if_instr stable; imem_req=0; fetch of 0x1004 issued the cycle after id_ready=1.
- br_taken in HOLD with br_pc=0x1004, br_immd=0x8 → if_valid=0 next cycle; flush=1 for one cycle; next imem_addr=0x1014.
- br_taken in WAIT (br_pc=0x1010, br_immd=-4) and rvalid 2 cycles later → response dropped, if_valid stays 0; next imem_addr=0x1008. Also br_pc=0, br_immd=-2 → imem_addr=0xFFFF_FFFF_FFFF_FFFC (wrap).
- rst_n=0 asynchronously mid-WAIT → all outputs 0 before the next edge; rvalid during/after reset ignored; first post-reset imem_addr=0x1000.
- With PC_MISALIGN_TRAP_EN: br_pc=0x1000, br_immd=0x1 (target 0x1002) → misalign_trap 1-cycle pulse; next imem_addr=0x100.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction memory port, IF/ID buffer, and redirect inputs.
// The sequencer connects through the master modport; the core/memory side uses slave.
interface pc_fetch_sequencer_if #(
   parameter int XLEN = 64
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic            id_ready;
   logic            br_taken;
   logic [XLEN-1:0] br_pc;
   logic [XLEN-1:0] br_immd;
   logic            flush;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output if_valid, if_pc, if_instr,
      input  id_ready,
      input  br_taken, br_pc, br_immd,
      output flush
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  if_valid, if_pc, if_instr,
      output id_ready,
      output br_taken, br_pc, br_immd,
      input  flush
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer with a one-entry IF buffer.
// Optional feature macro PC_MISALIGN_TRAP_EN: misaligned redirect targets vector to TRAP_VECTOR.
module pc_fetch_sequencer #(
   parameter int XLEN = 64,
`ifdef PC_MISALIGN_TRAP_EN
   parameter logic [XLEN-1:0] TRAP_VECTOR = 64'h0000_0000_0000_0100,
`endif
   parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0000_0000_0000_1000
) (
   input  logic clk,
   input  logic rst_n,
   pc_fetch_sequencer_if.master bus
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic misalign_trap
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

   state_t          state_r, state_s;
   logic [XLEN-1:0] pc_r, pc_s;
   logic [XLEN-1:0] pending_pc_r, pending_pc_s;
   logic            discard_r, discard_s;
   logic            if_valid_r, if_valid_s;
   logic [XLEN-1:0] if_pc_r, if_pc_s;
   logic [31:0]     if_instr_r, if_instr_s;
   logic            flush_r;
   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] redirect_pc_s;

   function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                     input logic [XLEN-1:0] immd);
      return pc + (immd << 1);
   endfunction

   assign target_s = branch_target(bus.br_pc, bus.br_immd);

`ifdef PC_MISALIGN_TRAP_EN
   logic misaligned_s;
   logic misalign_trap_r;

   assign misaligned_s  = (target_s[1:0] != 2'b00);
   assign redirect_pc_s = misaligned_s ? TRAP_VECTOR : target_s;
   assign misalign_trap = misalign_trap_r;

   // Trap pulse follows any redirect whose target was replaced by the trap vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_trap_r <= 1'b0;
      end else begin
         misalign_trap_r <= bus.br_taken && misaligned_s && (state_r != ST_IDLE);
      end
   end
`else
   assign redirect_pc_s = target_s;
`endif

   // Request lines are a pure decode of registered state and PC.
   assign bus.imem_req  = (state_r == ST_REQ);
   assign bus.imem_addr = (state_r == ST_REQ) ? pc_r : {XLEN{1'b0}};
   assign bus.if_valid  = if_valid_r;
   assign bus.if_pc     = if_pc_r;
   assign bus.if_instr  = if_instr_r;
   assign bus.flush     = flush_r;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         pc_r         <= RESET_VECTOR;
         pending_pc_r <= {XLEN{1'b0}};
         discard_r    <= 1'b0;
         if_valid_r   <= 1'b0;
         if_pc_r      <= {XLEN{1'b0}};
         if_instr_r   <= 32'h0000_0000;
         flush_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         pending_pc_r <= pending_pc_s;
         discard_r    <= discard_s;
         if_valid_r   <= if_valid_s;
         if_pc_r      <= if_pc_s;
         if_instr_r   <= if_instr_s;
         flush_r      <= bus.br_taken;
      end
   end

   // Next-state logic; a redirect always wins over the normal fetch flow.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      pending_pc_s = pending_pc_r;
      discard_s    = discard_r;
      if_valid_s   = if_valid_r;
      if_pc_s      = if_pc_r;
      if_instr_s   = if_instr_r;

      case (state_r)
         ST_IDLE: begin
            state_s = ST_REQ;
         end

         ST_REQ: begin
            if (bus.imem_gnt) begin
               state_s = ST_WAIT;
               if (bus.br_taken) begin
                  pc_s      = redirect_pc_s;
                  discard_s = 1'b1;
               end else begin
                  pending_pc_s = pc_r;
                  pc_s         = pc_r + PC_STEP;
               end
            end else if (bus.br_taken) begin
               pc_s = redirect_pc_s;
            end else begin
               state_s = ST_REQ;
            end
         end

         ST_WAIT: begin
            if (bus.br_taken) begin
               pc_s = redirect_pc_s;
            end else begin
               pc_s = pc_r;
            end
            // A response arriving with or after a redirect belongs to the wrong path.
            if (bus.imem_rvalid) begin
               if (discard_r || bus.br_taken) begin
                  discard_s = 1'b0;
                  state_s   = ST_REQ;
               end else begin
                  if_pc_s    = pending_pc_r;
                  if_instr_s = bus.imem_rdata;
                  if_valid_s = 1'b1;
                  state_s    = ST_HOLD;
               end
            end else if (bus.br_taken) begin
               discard_s = 1'b1;
            end else begin
               discard_s = discard_r;
            end
         end

         ST_HOLD: begin
            if (bus.br_taken) begin
               if_valid_s = 1'b0;
               pc_s       = redirect_pc_s;
               state_s    = ST_REQ;
            end else if (bus.id_ready) begin
               if_valid_s = 1'b0;
               state_s    = ST_REQ;
            end else begin
               if_valid_s = 1'b1;
            end
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

endmodule
